crop_stream_tx: RTL and testbench



---
 rtl/crop_stream_pkg.sv | 17 +
 rtl/axis_skid_buffer.sv | 53 +++++
 rtl/crop_stream_tx.sv | 148 ++++++++++++++
 tb/tb_crop_stream_tx.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/crop_stream_pkg.sv
// Shared types and default geometry for the crop_stream_tx streaming crop front-end.
package crop_stream_pkg;

    localparam int DEF_FP_TOTAL = 16;
    localparam int DEF_IN_ROWS  = 100;
    localparam int DEF_IN_COLS  = 160;
    localparam int DEF_OUT_ROWS = 48;
    localparam int DEF_OUT_COLS = 48;

    localparam int ROW_W = $clog2(DEF_IN_ROWS);
    localparam int COL_W = $clog2(DEF_IN_COLS);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} crop_state_t;

    typedef logic [DEF_FP_TOTAL-1:0] pixel_t;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-stream FIFO; in_ready comes from the registered fill count so the
// downstream ready never reaches the upstream ready combinationally.
module axis_skid_buffer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         push;
    logic         pop;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr];
    assign pop       = out_valid && out_ready;
    // A full buffer still takes a write when the head leaves in the same cycle.
    assign push      = in_valid && (in_ready || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/crop_stream_tx.sv
// Streaming crop: consumes a raster IN_ROWS x IN_COLS frame and emits the OUT_ROWS x OUT_COLS
// window at the clamped origin (y_1, x_1). Define CROP_STREAM_TLAST_EN to add crop_out TLAST.
module crop_stream_tx
    import crop_stream_pkg::*;
#(
    parameter int FP_TOTAL = DEF_FP_TOTAL,
    parameter int IN_ROWS  = DEF_IN_ROWS,
    parameter int IN_COLS  = DEF_IN_COLS,
    parameter int OUT_ROWS = DEF_OUT_ROWS,
    parameter int OUT_COLS = DEF_OUT_COLS
) (
    input  logic                       ap_clk,
    input  logic                       ap_rst,
    input  logic                       ap_start,
    output logic                       ap_done,
    output logic                       ap_idle,
    output logic                       ap_ready,
    input  logic [$clog2(IN_ROWS)-1:0] y_1,
    input  logic [$clog2(IN_COLS)-1:0] x_1,
    input  logic [FP_TOTAL-1:0]        frame_in_V_data_0_V_TDATA,
    input  logic                       frame_in_V_data_0_V_TVALID,
    output logic                       frame_in_V_data_0_V_TREADY,
    output logic [FP_TOTAL-1:0]        crop_out_V_data_0_V_TDATA,
    output logic                       crop_out_V_data_0_V_TVALID,
    input  logic                       crop_out_V_data_0_V_TREADY
`ifdef CROP_STREAM_TLAST_EN
    ,
    output logic                       crop_out_V_data_0_V_TLAST
`endif
);

    localparam int RW = $clog2(IN_ROWS);
    localparam int CW = $clog2(IN_COLS);
    localparam logic [RW-1:0] Y_MAX    = RW'(IN_ROWS - OUT_ROWS);
    localparam logic [CW-1:0] X_MAX    = CW'(IN_COLS - OUT_COLS);
    localparam logic [RW-1:0] LAST_ROW = RW'(IN_ROWS - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(IN_COLS - 1);

    crop_state_t   state;
    crop_state_t   state_nxt;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic [RW-1:0] y0;
    logic [CW-1:0] x0;
    logic          done_q;
    logic          buf_ready;
    logic          buf_valid;
    logic          hs;
    logic          row_in;
    logic          col_in;
    logic          push;
    logic          frame_end;

    // Window bounds compared one bit wider so origin + extent cannot wrap.
    assign row_in = (row >= y0) &&
                    ({1'b0, row} <= ({1'b0, y0} + (RW+1)'(OUT_ROWS - 1)));
    assign col_in = (col >= x0) &&
                    ({1'b0, col} <= ({1'b0, x0} + (CW+1)'(OUT_COLS - 1)));

    assign frame_in_V_data_0_V_TREADY = (state == RUN) && buf_ready;
    assign hs        = frame_in_V_data_0_V_TVALID && frame_in_V_data_0_V_TREADY;
    assign push      = hs && row_in && col_in;
    assign frame_end = (row == LAST_ROW) && (col == LAST_COL);
    assign ap_idle   = (state == IDLE);
    assign ap_done   = done_q;

    always_comb begin
        state_nxt = state;
        ap_ready  = 1'b0;
        case (state)
            IDLE: begin
                if (ap_start) begin
                    state_nxt = RUN;
                    ap_ready  = 1'b1;
                end
            end
            RUN: begin
                if (hs && frame_end) state_nxt = FLUSH;
            end
            FLUSH: begin
                if (!buf_valid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state  <= IDLE;
            row    <= '0;
            col    <= '0;
            y0     <= '0;
            x0     <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= (state == FLUSH) && !buf_valid;
            if (state == IDLE && ap_start) begin
                y0  <= (y_1 > Y_MAX) ? Y_MAX : y_1;
                x0  <= (x_1 > X_MAX) ? X_MAX : x_1;
                row <= '0;
                col <= '0;
            end else if (hs) begin
                if (col == LAST_COL) begin
                    col <= '0;
                    row <= (row == LAST_ROW) ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

`ifdef CROP_STREAM_TLAST_EN
    localparam int BW = FP_TOTAL + 1;
    logic          win_last;
    logic [BW-1:0] buf_in;
    logic [BW-1:0] buf_out;

    assign win_last = ({1'b0, row} == ({1'b0, y0} + (RW+1)'(OUT_ROWS - 1))) &&
                      ({1'b0, col} == ({1'b0, x0} + (CW+1)'(OUT_COLS - 1)));
    assign buf_in   = {win_last, frame_in_V_data_0_V_TDATA};
    assign {crop_out_V_data_0_V_TLAST, crop_out_V_data_0_V_TDATA} = buf_out;
`else
    localparam int BW = FP_TOTAL;
    logic [BW-1:0] buf_in;
    logic [BW-1:0] buf_out;

    assign buf_in                    = frame_in_V_data_0_V_TDATA;
    assign crop_out_V_data_0_V_TDATA = buf_out;
`endif

    axis_skid_buffer #(
        .W(BW)
    ) u_skid (
        .clk      (ap_clk),
        .rst      (ap_rst),
        .in_data  (buf_in),
        .in_valid (push),
        .in_ready (buf_ready),
        .out_data (buf_out),
        .out_valid(buf_valid),
        .out_ready(crop_out_V_data_0_V_TREADY)
    );

    assign crop_out_V_data_0_V_TVALID = buf_valid;

endmodule

// File: tb/tb_crop_stream_tx.sv
// Self-checking bench for crop_stream_tx against a window-extraction reference model.
module tb_crop_stream_tx;
    import crop_stream_pkg::*;

    localparam int IN_ROWS  = 100;
    localparam int IN_COLS  = 160;
    localparam int OUT_ROWS = 48;
    localparam int OUT_COLS = 48;
    localparam int N_IN     = IN_ROWS * IN_COLS;
    localparam int N_OUT    = OUT_ROWS * OUT_COLS;
    localparam int CYC_MAX  = 40000;

    logic       ap_clk = 1'b0;
    logic       ap_rst;
    logic       ap_start;
    logic       ap_done;
    logic       ap_idle;
    logic       ap_ready;
    logic [6:0] y_1;
    logic [7:0] x_1;
    pixel_t     in_data;
    logic       in_valid;
    logic       in_ready;
    pixel_t     out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    int          last_pos[$];
    int          win_y;
    int          win_x;
    int          hold_viol;
    int          busy_ready;
    int          done_idx;
    int          stall_acc;
    bit          timeout;
    bit          saw_done;
    logic        start_ack;
    logic        tready_at_stall_end;

    always #5 ap_clk = ~ap_clk;

    crop_stream_tx dut (
        .ap_clk                    (ap_clk),
        .ap_rst                    (ap_rst),
        .ap_start                  (ap_start),
        .ap_done                   (ap_done),
        .ap_idle                   (ap_idle),
        .ap_ready                  (ap_ready),
        .y_1                       (y_1),
        .x_1                       (x_1),
        .frame_in_V_data_0_V_TDATA (in_data),
        .frame_in_V_data_0_V_TVALID(in_valid),
        .frame_in_V_data_0_V_TREADY(in_ready),
        .crop_out_V_data_0_V_TDATA (out_data),
        .crop_out_V_data_0_V_TVALID(out_valid),
        .crop_out_V_data_0_V_TREADY(out_ready)
`ifdef CROP_STREAM_TLAST_EN
        ,
        .crop_out_V_data_0_V_TLAST (out_last)
`endif
    );

`ifndef CROP_STREAM_TLAST_EN
    assign out_last = 1'b0;
`endif

    // Reference: clamp origin, then list window pixels in raster order.
    task automatic build_exp(input int y, input int x);
        win_y = (y > IN_ROWS - OUT_ROWS) ? IN_ROWS - OUT_ROWS : y;
        win_x = (x > IN_COLS - OUT_COLS) ? IN_COLS - OUT_COLS : x;
        exp_q.delete();
        for (int r = win_y; r < win_y + OUT_ROWS; r++)
            for (int c = win_x; c < win_x + OUT_COLS; c++)
                exp_q.push_back(16'((r * IN_COLS + c) % 65536));
    endtask

    function automatic bit in_win(input int idx);
        int r = idx / IN_COLS;
        int c = idx % IN_COLS;
        return (r >= win_y) && (r < win_y + OUT_ROWS) && (c >= win_x) && (c < win_x + OUT_COLS);
    endfunction

    task automatic do_reset();
        @(posedge ap_clk); #1;
        ap_rst = 1'b1; ap_start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        y_1 = '0; x_1 = '0; in_data = '0;
        repeat (3) @(posedge ap_clk);
        #1 ap_rst = 1'b0;
    endtask

    // Drives one frame and records every output beat; stops at ap_done, at stop_at outputs, or on budget.
    task automatic run_frame(input int y, input int x, input bit rnd_in, input bit rnd_out,
                             input int stall_at, input int stop_at, input bit poke_start);
        int   idx = 0;
        int   cyc = 0;
        int   stall_left = 0;
        bit   stall_begun = 0;
        bit   prev_stuck = 0;
        pixel_t prev_data = '0;
        build_exp(y, x);
        got_q.delete(); last_pos.delete();
        hold_viol = 0; busy_ready = 0; done_idx = -1; stall_acc = 0;
        timeout = 0; saw_done = 0; tready_at_stall_end = 1'b1;
        @(posedge ap_clk); #1;
        y_1 = 7'(y); x_1 = 8'(x); ap_start = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge ap_clk);
        start_ack = ap_ready;
        @(posedge ap_clk); #1;
        ap_start = 1'b0;
        while (!saw_done && !(stop_at > 0 && got_q.size() >= stop_at) && !timeout) begin
            if (stall_at >= 0 && !stall_begun && got_q.size() >= stall_at) begin
                stall_begun = 1;
                stall_left  = 50;
            end
            in_valid  = (idx < N_IN) && (!rnd_in || ($urandom % 2 == 1));
            in_data   = pixel_t'(((idx / IN_COLS) * IN_COLS + idx % IN_COLS) % 65536);
            out_ready = (stall_left > 0) ? 1'b0 : (!rnd_out || ($urandom % 2 == 1));
            ap_start  = poke_start && (cyc == 200);
            @(negedge ap_clk);
            if (ap_ready) busy_ready++;
            if (prev_stuck && (out_valid !== 1'b1 || out_data !== prev_data)) hold_viol++;
            prev_stuck = out_valid && !out_ready;
            prev_data  = out_data;
            if (in_valid && in_ready) begin
                if (stall_left > 0 && in_win(idx)) stall_acc++;
                idx++;
            end
            if (stall_left > 0) begin
                if (stall_left == 1) tready_at_stall_end = in_ready;
                stall_left--;
            end
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                if (out_last) last_pos.push_back(got_q.size());
            end
            if (ap_done) begin
                saw_done = 1;
                done_idx = idx;
            end
            cyc++;
            if (cyc >= CYC_MAX) timeout = 1;
            @(posedge ap_clk); #1;
        end
        ap_start = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge ap_clk);
        total++;
        if ({ap_idle, ap_done, ap_ready, out_valid, in_ready} !== 5'b10000) begin
            bad++;
            $display("FAIL reset_state: idle/done/ready/ovalid/iready=%b want 10000",
                     {ap_idle, ap_done, ap_ready, out_valid, in_ready});
        end
    endtask

    task automatic test_nominal();
        int shown = 0;
        run_frame(10, 10, 0, 0, -1, 0, 0);
        total++; if (start_ack !== 1'b1) begin bad++; $display("FAIL nom_ap_ready: got %b want 1", start_ack); end
        total++; if (timeout) begin bad++; $display("FAIL nom_timeout: got 1 want 0"); end
        total++; if (got_q.size() != N_OUT) begin bad++; $display("FAIL nom_count: got %0d want %0d", got_q.size(), N_OUT); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++;
                if (shown++ < 5) $display("FAIL nom_data[%0d]: got %0d want %0d", i, got_q[i], exp_q[i]);
            end
        end
        total++; if (got_q[0] !== 16'd1610) begin bad++; $display("FAIL nom_first: got %0d want 1610", got_q[0]); end
        total++; if (got_q[48] !== 16'd1770) begin bad++; $display("FAIL nom_49th: got %0d want 1770", got_q[48]); end
        total++; if (got_q[N_OUT-1] !== 16'd9177) begin bad++; $display("FAIL nom_last: got %0d want 9177", got_q[N_OUT-1]); end
        total++; if (done_idx != N_IN) begin bad++; $display("FAIL nom_done_beats: got %0d want %0d", done_idx, N_IN); end
        @(negedge ap_clk);
        total++;
        if (ap_done !== 1'b0 || ap_idle !== 1'b1) begin
            bad++; $display("FAIL nom_done_pulse: done=%b idle=%b want 0 1", ap_done, ap_idle);
        end
    endtask

    task automatic test_backpressure();
        int shown = 0;
        run_frame(10, 10, 1, 1, -1, N_OUT, 0);
        total++; if (timeout) begin bad++; $display("FAIL bp_timeout: got 1 want 0"); end
        total++; if (got_q.size() != N_OUT) begin bad++; $display("FAIL bp_count: got %0d want %0d", got_q.size(), N_OUT); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++;
                if (shown++ < 5) $display("FAIL bp_data[%0d]: got %0d want %0d", i, got_q[i], exp_q[i]);
            end
        end
        total++; if (hold_viol != 0) begin bad++; $display("FAIL bp_hold: got %0d changes want 0", hold_viol); end
    endtask

    task automatic test_clamp_stall();
        int shown = 0;
        do_reset();
        run_frame(80, 150, 0, 0, 500, 0, 0);
        total++; if (timeout) begin bad++; $display("FAIL clamp_timeout: got 1 want 0"); end
        total++; if (got_q.size() != N_OUT) begin bad++; $display("FAIL clamp_count: got %0d want %0d", got_q.size(), N_OUT); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++;
                if (shown++ < 5) $display("FAIL clamp_data[%0d]: got %0d want %0d", i, got_q[i], exp_q[i]);
            end
        end
        total++; if (got_q[0] !== 16'd8432) begin bad++; $display("FAIL clamp_first: got %0d want 8432", got_q[0]); end
        total++; if (got_q[N_OUT-1] !== 16'd15999) begin bad++; $display("FAIL clamp_last: got %0d want 15999", got_q[N_OUT-1]); end
        total++; if (done_idx != N_IN) begin bad++; $display("FAIL clamp_done_beats: got %0d want %0d", done_idx, N_IN); end
        total++; if (stall_acc > 2) begin bad++; $display("FAIL stall_accepts: got %0d want <=2", stall_acc); end
        total++; if (tready_at_stall_end !== 1'b0) begin bad++; $display("FAIL stall_tready: got %b want 0", tready_at_stall_end); end
    endtask

    task automatic test_reset_mid();
        run_frame(10, 10, 0, 0, -1, 500, 0);
        total++; if (got_q.size() != 500) begin bad++; $display("FAIL rst_pre_count: got %0d want 500", got_q.size()); end
        in_valid = 1'b0; out_ready = 1'b0; ap_rst = 1'b1;
        @(posedge ap_clk); #1;
        ap_rst = 1'b0;
        @(negedge ap_clk);
        total++;
        if ({ap_idle, ap_done, ap_ready, out_valid, in_ready} !== 5'b10000) begin
            bad++;
            $display("FAIL rst_mid_state: idle/done/ready/ovalid/iready=%b want 10000",
                     {ap_idle, ap_done, ap_ready, out_valid, in_ready});
        end
    endtask

    task automatic test_start_busy();
        int shown = 0;
        run_frame(0, 0, 0, 0, -1, N_OUT, 1);
        total++; if (start_ack !== 1'b1) begin bad++; $display("FAIL busy_ap_ready_start: got %b want 1", start_ack); end
        total++; if (timeout) begin bad++; $display("FAIL busy_timeout: got 1 want 0"); end
        total++; if (busy_ready != 0) begin bad++; $display("FAIL busy_ap_ready: got %0d pulses want 0", busy_ready); end
        total++; if (got_q.size() != N_OUT) begin bad++; $display("FAIL busy_count: got %0d want %0d", got_q.size(), N_OUT); end
        total++; if (got_q[0] !== 16'd0) begin bad++; $display("FAIL busy_first: got %0d want 0", got_q[0]); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++;
                if (shown++ < 5) $display("FAIL busy_data[%0d]: got %0d want %0d", i, got_q[i], exp_q[i]);
            end
        end
`ifdef CROP_STREAM_TLAST_EN
        total++;
        if (last_pos.size() != 1 || last_pos[0] != N_OUT) begin
            bad++;
            $display("FAIL tlast: got %0d marks first at %0d want 1 mark at %0d",
                     last_pos.size(), (last_pos.size() > 0) ? last_pos[0] : -1, N_OUT);
        end
`endif
    endtask

    initial begin
        do_reset();
        test_reset();
        test_nominal();
        test_backpressure();
        test_clamp_stall();
        test_reset_mid();
        test_start_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
